// File: rtl/bcd_to_binary.sv
// ----------------------------------------------------------------------------
// bcd_to_binary : multi-cycle packed-BCD to unsigned binary converter
//                 (reverse double-dabble, one digit corrected per cycle)
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_to_binary #(
  parameter int OUTPUT_LENGTH = 8,
  parameter int N_DIGITS      = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [N_DIGITS*4-1:0]    bcd,
  output logic [OUTPUT_LENGTH-1:0] binary,
  output logic                     completed,
  output logic                     invalid
);

  localparam int c_BCD_W = N_DIGITS * 4;
  localparam int c_SC_W  = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;
  localparam int c_DI_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [c_SC_W-1:0] c_LAST_SHIFT = c_SC_W'(OUTPUT_LENGTH - 1);
  localparam logic [c_DI_W-1:0] c_LAST_DIGIT = c_DI_W'(N_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_SHIFT         = 3'd1,
    S_CHECK_SHIFT   = 3'd2,
    S_SUBTRACT      = 3'd3,
    S_CHECK_DIGIT   = 3'd4,
    S_FINISHED      = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [c_BCD_W-1:0]       r_bcd_buf;
  logic [OUTPUT_LENGTH-1:0] r_bin_buf;
  logic                     r_invalid_buf;
  logic [c_SC_W-1:0]        r_shift_count;
  logic [c_DI_W-1:0]        r_digit_index;
  logic                     w_any_invalid;
  logic [c_BCD_W-1:0]       w_bcd_sub;

  always_comb begin
    w_any_invalid = 1'b0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (bcd[d*4 +: 4] > 4'd9) w_any_invalid = 1'b1;
    end
  end

  // Only the nibble selected by r_digit_index is corrected this cycle.
  always_comb begin
    w_bcd_sub = r_bcd_buf;
    for (int d = 0; d < N_DIGITS; d++) begin
      if ((c_DI_W'(d) == r_digit_index) && r_bcd_buf[d*4+3]) begin
        w_bcd_sub[d*4 +: 4] = r_bcd_buf[d*4 +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE:        w_state_next = start ? S_SHIFT : S_IDLE;
      S_SHIFT:       w_state_next = S_CHECK_SHIFT;
      S_CHECK_SHIFT: w_state_next = (r_shift_count == c_LAST_SHIFT) ? S_FINISHED : S_SUBTRACT;
      S_SUBTRACT:    w_state_next = S_CHECK_DIGIT;
      S_CHECK_DIGIT: w_state_next = (r_digit_index == c_LAST_DIGIT) ? S_SHIFT : S_SUBTRACT;
      S_FINISHED:    w_state_next = S_IDLE;
      default:       w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd_buf     <= '0;
      r_bin_buf     <= '0;
      r_invalid_buf <= 1'b0;
      r_shift_count <= '0;
      r_digit_index <= '0;
      binary        <= '0;
      completed     <= 1'b0;
      invalid       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          completed <= 1'b0;
          if (start) begin
            r_bcd_buf     <= bcd;
            r_bin_buf     <= '0;
            r_invalid_buf <= w_any_invalid;
          end
        end
        S_SHIFT: begin
          {r_bcd_buf, r_bin_buf} <= {r_bcd_buf, r_bin_buf} >> 1;
        end
        S_CHECK_SHIFT: begin
          if (r_shift_count == c_LAST_SHIFT) r_shift_count <= '0;
          else                               r_shift_count <= r_shift_count + 1'b1;
        end
        S_SUBTRACT: begin
          r_bcd_buf <= w_bcd_sub;
        end
        S_CHECK_DIGIT: begin
          if (r_digit_index == c_LAST_DIGIT) r_digit_index <= '0;
          else                               r_digit_index <= r_digit_index + 1'b1;
        end
        S_FINISHED: begin
          binary    <= r_bin_buf;
          invalid   <= r_invalid_buf;
          completed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_binary : scoreboard bench for bcd_to_binary (three parameter sets)
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_to_binary;

  typedef struct {
    logic [63:0] bin;
    logic        inv;
    bit          chk_bin;
    longint      due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start0, start1, start2;
  logic [7:0]  bcd0;
  logic [11:0] bcd1, bcd2;
  logic [7:0]  binary0;
  logic [9:0]  binary1;
  logic [7:0]  binary2;
  logic        completed0, completed1, completed2;
  logic        invalid0, invalid1, invalid2;
  logic        prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];

  bcd_to_binary #(.OUTPUT_LENGTH(8), .N_DIGITS(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .bcd(bcd0),
    .binary(binary0), .completed(completed0), .invalid(invalid0));

  bcd_to_binary #(.OUTPUT_LENGTH(10), .N_DIGITS(3)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .bcd(bcd1),
    .binary(binary1), .completed(completed1), .invalid(invalid1));

  bcd_to_binary #(.OUTPUT_LENGTH(8), .N_DIGITS(3)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .bcd(bcd2),
    .binary(binary2), .completed(completed2), .invalid(invalid2));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int id, input logic [63:0] b, input logic inv, input longint due);
    exp_t e;
    e.bin = b; e.inv = inv; e.chk_bin = !inv; e.due = due;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic on_done(input int id, input logic [63:0] got_bin, input logic got_inv);
    exp_t e;
    int   n;
    n = qsize(id);
    check_eq("pending", 64'(n != 0), 64'd1);
    if (n != 0) begin
      if (id == 0)      e = q0.pop_front();
      else if (id == 1) e = q1.pop_front();
      else              e = q2.pop_front();
      check_eq("latency", 64'(cyc), 64'(e.due));
      if (e.chk_bin) check_eq("binary", got_bin, e.bin);
      check_eq("invalid", 64'(got_inv), 64'(e.inv));
    end
  endtask

  always @(negedge clock) begin
    if (completed0) begin
      check_eq("width0", 64'(prev0), 64'd0);
      on_done(0, 64'(binary0), invalid0);
    end
    if (completed1) begin
      check_eq("width1", 64'(prev1), 64'd0);
      on_done(1, 64'(binary1), invalid1);
    end
    if (completed2) begin
      check_eq("width2", 64'(prev2), 64'd0);
      on_done(2, 64'(binary2), invalid2);
    end
    prev0 <= completed0;
    prev1 <= completed1;
    prev2 <= completed2;
  end

  // Called at a falling edge; the following rising edge is edge 0.
  task automatic launch(input int id, input logic [63:0] b, input logic [63:0] exp_bin,
                        input logic exp_inv, input int lat);
    push_exp(id, exp_bin, exp_inv, cyc + 1 + lat);
    case (id)
      0:       begin bcd0 = b[7:0];  start0 = 1'b1; end
      1:       begin bcd1 = b[11:0]; start1 = 1'b1; end
      default: begin bcd2 = b[11:0]; start2 = 1'b1; end
    endcase
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int id);
    for (int i = 0; i < 300; i++) begin
      if (qsize(id) == 0) break;
      @(negedge clock);
      #1;
    end
    check_eq("drain", 64'(qsize(id)), 64'd0);
    if (id == 0) q0.delete();
    else if (id == 1) q1.delete();
    else q2.delete();
  endtask

  logic [7:0] tbl_bcd [4] = '{8'h00, 8'h42, 8'h99, 8'h10};
  logic [7:0] tbl_exp [4] = '{8'h00, 8'h2A, 8'h63, 8'h0A};

  initial begin
    reset_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bcd0 = '0; bcd1 = '0; bcd2 = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_binary",    64'(binary0),    64'd0);
    check_eq("rst_completed", 64'(completed0), 64'd0);
    check_eq("rst_invalid",   64'(invalid0),   64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      launch(0, 64'(tbl_bcd[i]), 64'(tbl_exp[i]), 1'b0, 45);
      wait_done(0);
      repeat (4) @(negedge clock);
      check_eq("hold", 64'(binary0), 64'(tbl_exp[i]));
    end

    launch(0, 64'h0A5, 64'h0, 1'b1, 45);
    wait_done(0);
    @(negedge clock);
    launch(0, 64'h007, 64'h07, 1'b0, 45);
    wait_done(0);
    @(negedge clock);

    // Wider and overflowing parameter sets run concurrently.
    launch(1, 64'h999, 64'h3E7, 1'b0, 75);
    launch(2, 64'h300, 64'h2C, 1'b0, 59);
    wait_done(1);
    wait_done(2);
    @(negedge clock);
    launch(1, 64'h512, 64'h200, 1'b0, 75);
    launch(2, 64'h255, 64'hFF, 1'b0, 59);
    wait_done(1);
    wait_done(2);
    @(negedge clock);

    // A start while busy must be ignored.
    launch(0, 64'h42, 64'h2A, 1'b0, 45);
    repeat (10) @(negedge clock);
    bcd0 = 8'h99; start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    wait_done(0);
    @(negedge clock);

    // start held high: second capture on the completed cycle, with bcd changed mid-run.
    push_exp(0, 64'h2A, 1'b0, cyc + 46);
    push_exp(0, 64'h11, 1'b0, cyc + 92);
    bcd0 = 8'h42; start0 = 1'b1;
    @(negedge clock);
    bcd0 = 8'h17;
    for (int i = 0; i < 100; i++) begin
      if (qsize(0) <= 1) break;
      @(negedge clock);
      #1;
    end
    @(negedge clock);
    start0 = 1'b0;
    wait_done(0);
    @(negedge clock);

    // Asynchronous reset at edge 20 of a conversion aborts it silently.
    launch(0, 64'h55, 64'h37, 1'b0, 45);
    repeat (20) @(posedge clock);
    #1;
    reset_n = 1'b0;
    q0.delete();
    #1;
    check_eq("abort_binary",    64'(binary0),    64'd0);
    check_eq("abort_completed", 64'(completed0), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    launch(0, 64'h63, 64'h3F, 1'b0, 45);
    wait_done(0);
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential BCD-to-binary converter using the reverse double-dabble algorithm: shift right, then subtract 3 from each nibble ≥ 8.
- Packed BCD in, unsigned binary out, with a start/completed pulse handshake.
- Used wherever decimal values (score entry, settings, digit counters) must return to binary for arithmetic or comparison.
- Multi-cycle, one digit corrected per cycle; small area, no combinational adder chain across all digits.

Parameters:
- OUTPUT_LENGTH, 8: width of the binary result (1..64).
- N_DIGITS, 2: number of BCD digits in the input (1..16).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd  input  N_DIGITS*4  packed BCD, digit 0 in bits [3:0]; captured on the accepted start.
- binary  output  OUTPUT_LENGTH  result; registered, holds its value between conversions.
- completed  output  1  one-cycle pulse marking a new result.
- invalid  output  1  registered alongside completed; 1 if any captured nibble was > 9.

Behaviour:
- Reset (async assert, sync release): state=IDLE; binary=0, completed=0, invalid=0; working registers and counters cleared. Reset mid-conversion aborts with no completed pulse.
- Working register: {bcd_buf[N_DIGITS*4-1:0], bin_buf[OUTPUT_LENGTH-1:0]}; shift_count; digit_index.
- IDLE:
  - completed <= 0.
  - On start=1: bcd_buf <= bcd, bin_buf <= 0, invalid_buf <= (any nibble of bcd > 9), go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: whole working register shifts right by 1; bcd_buf[0] enters bin_buf MSB; 0 enters bcd_buf MSB; go to CHECK_SHIFT_INDEX.
- CHECK_SHIFT_INDEX:
  - If shift_count == OUTPUT_LENGTH-1: shift_count <= 0, go to FINISHED.
  - Else: shift_count++, go to SUBTRACT.
- SUBTRACT: if nibble[digit_index] ≥ 8, subtract 3 (4-bit, no borrow out); go to CHECK_DIGIT_INDEX.
- CHECK_DIGIT_INDEX:
  - If digit_index == N_DIGITS-1: digit_index <= 0, go to SHIFT.
  - Else: digit_index++, go to SUBTRACT.
- FINISHED: binary <= bin_buf, invalid <= invalid_buf, completed <= 1, go to IDLE.
- Latency: counting the start-sampling edge as edge 0, completed is high after edge (OUTPUT_LENGTH-1)*(2+2*N_DIGITS)+3. For defaults that is edge 45. completed stays high for exactly 1 cycle.
- start while busy (any state except IDLE) is ignored; no queuing.
- start held high: the next conversion is accepted in the IDLE cycle in which completed is high (back-to-back operation).
- binary and invalid change only in FINISHED; they are never exposed mid-conversion.
- Overflow: if the decimal value ≥ 2^OUTPUT_LENGTH, binary = value mod 2^OUTPUT_LENGTH. There is no flag for this.
- Invalid digits (> 9): binary is deterministic but unspecified; invalid=1.
- bcd changes after capture have no effect on the conversion in progress.
- The last shift has no SUBTRACT pass after it.
- Unused state encodings go to IDLE.

Test Plan:
- Defaults; bcd=0x00, start pulse -> completed at edge 45; binary=0x00, invalid=0.
- Defaults; bcd=0x42, then 0x99, then 0x10 -> binary=0x2A, 0x63, 0x0A respectively. completed is 1 cycle wide each time; binary holds between runs.
- Defaults; bcd=0xA5 -> invalid=1 at completed. A following bcd=0x07 -> binary=0x07, invalid=0.
- N_DIGITS=3, OUTPUT_LENGTH=10; bcd=0x999 -> binary=0x3E7. Overflow case OUTPUT_LENGTH=8, N_DIGITS=3, bcd=0x300 -> binary=0x2C (300 mod 256).
- Defaults; start re-pulsed mid-conversion with a different bcd -> ignored, original result produced. start held high -> back-to-back results, second run accepted on the completed cycle.
- Defaults; reset_n low at edge 20 of a conversion -> binary=0, completed=0 immediately (asynchronous). No pulse follows; a new start after release converts correctly.
